// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - four-way round-robin arbiter for a shared 2-to-4 decoder (optional hold timeout: RRA_TIMEOUT_EN)
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [1:0] gnt_id_next;
    logic       busy_next;
    logic       timeout_next;
    logic [3:0] gnt_next;
    logic [1:0] sel;
    logic       hit;
    logic       release_req;
    logic       expire;

    // A hold limit outside 2..255 cannot be represented by the 8-bit hold counter.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_decode_arbiter: MAX_HOLD must be in 2..255");
    end

`ifdef RRA_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Hold counter: parked at zero while idle so every new grant starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= 8'd0;
        end
    end

    assign expire = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign expire = 1'b0;
`endif

    // Owner gives the decoder back by strobing done or dropping its own request.
    assign release_req = done || !req[gnt_id];

    // Round-robin scan starting at ptr; the lowest offset with a request wins.
    always_comb begin
        hit = 1'b0;
        sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                hit = 1'b1;
                sel = ptr + 2'(k);
            end
        end
    end

    // Next-state and next registered outputs; defaults hold the current values.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        gnt_id_next  = gnt_id;
        busy_next    = busy;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next  = GRANT;
                    gnt_id_next = sel;
                    busy_next   = 1'b1;
                    ptr_next    = sel + 2'd1;
                end else begin
                    gnt_id_next = 2'd0;
                    busy_next   = 1'b0;
                end
            end
            GRANT: begin
                // A normal release on the expiry cycle takes priority, so no timeout pulse.
                if (release_req) begin
                    state_next  = IDLE;
                    gnt_id_next = 2'd0;
                    busy_next   = 1'b0;
                end else if (expire) begin
                    state_next   = IDLE;
                    gnt_id_next  = 2'd0;
                    busy_next    = 1'b0;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_id_next = 2'd0;
                busy_next   = 1'b0;
            end
        endcase
        gnt_next = busy_next ? (4'b0001 << gnt_id_next) : 4'b0000;
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            gnt     <= 4'b0000;
            gnt_id  <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            gnt     <= gnt_next;
            gnt_id  <= gnt_id_next;
            busy    <= busy_next;
            timeout <= timeout_next;
        end
    end

endmodule
